change_dispenser: RTL and testbench

Payout end of the vending datapath: accepts a 6-bit change amount from the vending FSM, pays it out through a coin hopper as 10- and 5-unit coins (largest first), and tracks the coin stock. Each coin is a command pulse, then a wait for the hopper's drop acknowledge. It reports unpaid residue and hopper faults back to the controller.

---
 rtl/change_dispenser.sv | 195 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Purpose : pays a 6-bit change amount out through a coin hopper as 10- then 5-unit coins
//           and tracks the two coin stocks.
// Latency : accept -> first eject pulse 2 cycles; 3+ cycles per coin; a zero payout gives done 2 cycles after accept.
// Backpr. : change_ready is high only in IDLE, so the requester holds change_valid until it is accepted.
//           Each coin waits for hopper_ack. After ACK_TIMEOUT silent cycles the block locks in FAULT until rst.
// Ports   : clk/rst (async, active-high); change_valid/change_amount/change_ready request handshake;
//           refill_5/refill_10 stock top-up (IDLE only); eject_5/eject_10 hopper commands, hopper_ack drop confirm;
//           done payout-finished pulse, shortfall unpaid residue, fault sticky hopper timeout;
//           stock_5/stock_10 current coin counts.
module change_dispenser #(
    parameter int COIN5_INIT  = 8,
    parameter int COIN10_INIT = 8,
    parameter int STOCK_W     = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               change_valid,
    input  logic [5:0]         change_amount,
    output logic               change_ready,
    input  logic               refill_5,
    input  logic               refill_10,
    output logic               eject_5,
    output logic               eject_10,
    input  logic               hopper_ack,
    output logic               done,
    output logic [5:0]         shortfall,
    output logic               fault,
    output logic [STOCK_W-1:0] stock_5,
    output logic [STOCK_W-1:0] stock_10
);

    // Timer counts completed ack-less WAIT_ACK cycles. The last allowed cycle is ACK_TIMEOUT-1.
    localparam int                 TIMER_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [STOCK_W-1:0] STOCK_MAX  = {STOCK_W{1'b1}};
    localparam logic [STOCK_W-1:0] STOCK5_RST  = STOCK_W'(COIN5_INIT);
    localparam logic [STOCK_W-1:0] STOCK10_RST = STOCK_W'(COIN10_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_ACK,
        S_FINISH,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         remaining_q, remaining_d;
    logic               coin10_q, coin10_d;       // 1: current coin is a 10, 0: a 5
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [STOCK_W-1:0] stock5_q, stock5_d;
    logic [STOCK_W-1:0] stock10_q, stock10_d;
    logic [5:0]         shortfall_q, shortfall_d;

    // Output registers. They are loaded from the next state, so every output is a flop
    // that is aligned with the state it belongs to.
    logic               ready_q, ready_d;
    logic               eject5_q, eject5_d;
    logic               eject10_q, eject10_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;

    // Value of the coin currently in flight, as a 6-bit amount.
    logic [5:0]         coin_val;
    assign coin_val = coin10_q ? 6'd10 : 6'd5;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin10_d    = coin10_q;
        timer_d     = timer_q;
        stock5_d    = stock5_q;
        stock10_d   = stock10_q;
        shortfall_d = shortfall_q;

        case (state_q)
            S_IDLE: begin
                // Refills are independent and saturating. They are also honoured on the accept cycle.
                if (refill_5 && (stock5_q != STOCK_MAX)) begin
                    stock5_d = stock5_q + 1'b1;
                end
                if (refill_10 && (stock10_q != STOCK_MAX)) begin
                    stock10_d = stock10_q + 1'b1;
                end
                if (change_valid) begin
                    remaining_d = change_amount;
                    shortfall_d = 6'd0;
                    state_d     = S_SELECT;
                end
            end

            S_SELECT: begin
                if ((remaining_q >= 6'd10) && (stock10_q != '0)) begin
                    coin10_d = 1'b1;
                    state_d  = S_EJECT;
                end else if ((remaining_q >= 6'd5) && (stock5_q != '0)) begin
                    coin10_d = 1'b0;
                    state_d  = S_EJECT;
                end else begin
                    // Nothing more can be paid. Whatever is left is reported as shortfall.
                    shortfall_d = remaining_q;
                    state_d     = S_FINISH;
                end
            end

            S_EJECT: begin
                timer_d = '0;
                state_d = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                // The ack is checked before the timeout, so an ack on the last allowed cycle still counts.
                if (hopper_ack) begin
                    // SELECT only chose this coin when remaining >= coin, so the subtraction cannot underflow.
                    remaining_d = remaining_q - coin_val;
                    if (coin10_q) begin
                        if (stock10_q != '0) stock10_d = stock10_q - 1'b1;
                    end else begin
                        if (stock5_q != '0) stock5_d = stock5_q - 1'b1;
                    end
                    state_d = S_SELECT;
                end else if (timer_q == TIMER_LAST) begin
                    shortfall_d = remaining_q;
                    state_d     = S_FAULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            S_FAULT: begin
                // Terminal until reset. Requests, refills and acks are all ignored.
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, registered below.
    always_comb begin
        ready_d   = (state_d == S_IDLE);
        eject10_d = (state_d == S_EJECT) && coin10_d;
        eject5_d  = (state_d == S_EJECT) && !coin10_d;
        done_d    = (state_d == S_FINISH);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= 6'd0;
            coin10_q    <= 1'b0;
            timer_q     <= '0;
            stock5_q    <= STOCK5_RST;
            stock10_q   <= STOCK10_RST;
            shortfall_q <= 6'd0;
            ready_q     <= 1'b1;
            eject5_q    <= 1'b0;
            eject10_q   <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin10_q    <= coin10_d;
            timer_q     <= timer_d;
            stock5_q    <= stock5_d;
            stock10_q   <= stock10_d;
            shortfall_q <= shortfall_d;
            ready_q     <= ready_d;
            eject5_q    <= eject5_d;
            eject10_q   <= eject10_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign change_ready = ready_q;
    assign eject_5      = eject5_q;
    assign eject_10     = eject10_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign shortfall    = shortfall_q;
    assign stock_5      = stock5_q;
    assign stock_10     = stock10_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Purpose : directed bench for change_dispenser with hand-computed expectations.
// Latency : each payout is bounded by a 200-cycle budget.
// Backpr. : an auto-responder acks each eject after ack_dly cycles when ack_en is set.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] change_amount = 6'd0;
    logic       change_valid0 = 1'b0, change_valid1 = 1'b0;
    logic       refill_5 = 1'b0, refill_10 = 1'b0;
    logic       hopper_ack0, hopper_ack1;

    logic       change_ready0, eject_5_0, eject_10_0, done0, fault0;
    logic [5:0] shortfall0;
    logic [4:0] stock_5_0, stock_10_0;

    logic       change_ready1, eject_5_1, eject_10_1, done1, fault1;
    logic [5:0] shortfall1;
    logic [4:0] stock_5_1, stock_10_1;

    int n_vec = 0;
    int n_err = 0;

    int ack_en    = 1;
    int ack_dly   = 1;
    int force_ack = 0;
    int cnt0 = -1, cnt1 = -1;
    int ej0[$];
    int ej1[$];

    always #5 clk = ~clk;

    change_dispenser #(.COIN5_INIT(8), .COIN10_INIT(8), .STOCK_W(5), .ACK_TIMEOUT(15)) u_dut0 (
        .clk(clk), .rst(rst), .change_valid(change_valid0), .change_amount(change_amount),
        .change_ready(change_ready0), .refill_5(refill_5), .refill_10(refill_10),
        .eject_5(eject_5_0), .eject_10(eject_10_0), .hopper_ack(hopper_ack0), .done(done0),
        .shortfall(shortfall0), .fault(fault0), .stock_5(stock_5_0), .stock_10(stock_10_0)
    );

    change_dispenser #(.COIN5_INIT(1), .COIN10_INIT(1), .STOCK_W(5), .ACK_TIMEOUT(15)) u_dut1 (
        .clk(clk), .rst(rst), .change_valid(change_valid1), .change_amount(change_amount),
        .change_ready(change_ready1), .refill_5(refill_5), .refill_10(refill_10),
        .eject_5(eject_5_1), .eject_10(eject_10_1), .hopper_ack(hopper_ack1), .done(done1),
        .shortfall(shortfall1), .fault(fault1), .stock_5(stock_5_1), .stock_10(stock_10_1)
    );

    // Hopper model: this block records every eject and raises ack ack_dly+1 cycles later.
    always @(negedge clk) begin
        hopper_ack0 = (force_ack != 0);
        if (cnt0 == 0) begin
            hopper_ack0 = 1'b1;
            cnt0 = -1;
        end else if (cnt0 > 0) begin
            cnt0--;
        end
        if (eject_10_0) ej0.push_back(10);
        if (eject_5_0)  ej0.push_back(5);
        if ((ack_en != 0) && (eject_5_0 || eject_10_0)) cnt0 = ack_dly;
    end

    always @(negedge clk) begin
        hopper_ack1 = 1'b0;
        if (cnt1 == 0) begin
            hopper_ack1 = 1'b1;
            cnt1 = -1;
        end else if (cnt1 > 0) begin
            cnt1--;
        end
        if (eject_10_1) ej1.push_back(10);
        if (eject_5_1)  ej1.push_back(5);
        if ((ack_en != 0) && (eject_5_1 || eject_10_1)) cnt1 = ack_dly;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cnt0 = -1;
        cnt1 = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one request to the selected DUT. The task returns at the negedge of the first cycle after accept (n=1).
    task automatic accept(input int sel, input int amt);
        @(negedge clk);
        ej0.delete();
        ej1.delete();
        change_amount = 6'(amt);
        if (sel != 0) change_valid1 = 1'b1;
        else          change_valid0 = 1'b1;
        @(negedge clk);
        change_valid0 = 1'b0;
        change_valid1 = 1'b0;
    endtask

    // Counts cycles from accept until done is observed. The result is -1 if the budget runs out.
    task automatic wait_done(input int sel, output int n);
        n = 1;
        while (!((sel != 0) ? done1 : done0) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) n = -1;
    endtask

    task automatic pay(input int sel, input int amt, output int n);
        accept(sel, amt);
        wait_done(sel, n);
    endtask

    int n;
    int seen_done;

    initial begin
        // ---- reset state ----
        @(negedge clk);
        chk("rst_ready", change_ready0, 1);
        chk("rst_eject5", eject_5_0, 0);
        chk("rst_eject10", eject_10_0, 0);
        chk("rst_done", done0, 0);
        chk("rst_fault", fault0, 0);
        chk("rst_shortfall", shortfall0, 0);
        chk("rst_stock5", stock_5_0, 8);
        chk("rst_stock10", stock_10_0, 8);
        do_reset();

        // ---- 25 with stocks 8/8: 10,10,5 ----
        pay(0, 25, n);
        chk("p25_cycles", n, 14);
        chk("p25_nej", ej0.size(), 3);
        if (ej0.size() == 3) begin
            chk("p25_ej0", ej0[0], 10);
            chk("p25_ej1", ej0[1], 10);
            chk("p25_ej2", ej0[2], 5);
        end
        chk("p25_short", shortfall0, 0);
        chk("p25_stock10", stock_10_0, 6);
        chk("p25_stock5", stock_5_0, 7);
        @(negedge clk);
        chk("p25_done_1cyc", done0, 0);

        // ---- zero amount ----
        pay(0, 0, n);
        chk("p0_cycles", n, 2);
        chk("p0_nej", ej0.size(), 0);
        chk("p0_short", shortfall0, 0);

        // ---- 7: one 5-coin, residue 2 ----
        pay(0, 7, n);
        chk("p7_cycles", n, 6);
        chk("p7_nej", ej0.size(), 1);
        if (ej0.size() == 1) chk("p7_ej0", ej0[0], 5);
        chk("p7_short", shortfall0, 2);
        chk("p7_stock5", stock_5_0, 6);

        // ---- INIT=1 instance, 30: 10,5 then shortfall 15 ----
        do_reset();
        pay(1, 30, n);
        chk("p30_cycles", n, 10);
        chk("p30_nej", ej1.size(), 2);
        if (ej1.size() == 2) begin
            chk("p30_ej0", ej1[0], 10);
            chk("p30_ej1", ej1[1], 5);
        end
        chk("p30_short", shortfall1, 15);
        chk("p30_stock10", stock_10_1, 0);
        chk("p30_stock5", stock_5_1, 0);
        chk("p30_other_idle", stock_10_0, 8);

        // ---- ack on the 15th WAIT_ACK cycle still wins ----
        ack_dly = 14;
        pay(0, 10, n);
        chk("lastack_cycles", n, 19);
        chk("lastack_fault", fault0, 0);
        chk("lastack_short", shortfall0, 0);
        chk("lastack_stock10", stock_10_0, 7);
        ack_dly = 1;

        // ---- timeout into FAULT ----
        do_reset();
        ack_en = 0;
        accept(0, 10);
        seen_done = 0;
        n = 1;
        while (n < 17) begin
            @(negedge clk);
            n++;
            if (done0) seen_done = 1;
        end
        chk("to_fault_at17", fault0, 0);
        @(negedge clk);
        chk("to_fault_at18", fault0, 1);
        chk("to_ready", change_ready0, 0);
        chk("to_short", shortfall0, 10);
        chk("to_stock10", stock_10_0, 8);
        // Requests and acks during FAULT have no effect.
        change_amount = 6'd5;
        change_valid0 = 1'b1;
        force_ack = 1;
        repeat (3) begin
            @(negedge clk);
            if (done0) seen_done = 1;
        end
        change_valid0 = 1'b0;
        force_ack = 0;
        chk("to_no_done", seen_done, 0);
        chk("to_sticky", fault0, 1);
        chk("to_stock_hold", stock_10_0, 8);
        do_reset();
        chk("to_rst_fault", fault0, 0);
        chk("to_rst_ready", change_ready0, 1);
        chk("to_rst_stock10", stock_10_0, 8);

        // ---- async reset during WAIT_ACK of a 20 payout ----
        accept(0, 20);
        @(negedge clk);
        @(negedge clk);                 // n=3: first WAIT_ACK cycle
        chk("mr_ready_before", change_ready0, 0);
        #1 rst = 1'b1;
        #1;
        chk("mr_ready_async", change_ready0, 1);
        chk("mr_stock10_async", stock_10_0, 8);
        chk("mr_short_async", shortfall0, 0);
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1;
        @(negedge clk);
        force_ack = 0;
        @(negedge clk);
        chk("mr_late_ack_stock10", stock_10_0, 8);
        chk("mr_late_ack_ready", change_ready0, 1);
        ack_en = 1;
        pay(0, 20, n);
        chk("mr_pay_cycles", n, 10);
        chk("mr_pay_nej", ej0.size(), 2);
        chk("mr_pay_short", shortfall0, 0);
        chk("mr_pay_stock10", stock_10_0, 6);

        // ---- refill saturation and simultaneous refill ----
        @(negedge clk);
        refill_10 = 1'b1;
        repeat (40) @(negedge clk);
        refill_10 = 1'b0;
        chk("rf_sat10", stock_10_0, 31);
        refill_5  = 1'b1;
        refill_10 = 1'b1;
        @(negedge clk);
        refill_5  = 1'b0;
        refill_10 = 1'b0;
        chk("rf_both5", stock_5_0, 9);
        chk("rf_both10", stock_10_0, 31);

        // ---- refill_5 held during a payout is ignored ----
        accept(0, 5);
        refill_5 = 1'b1;
        wait_done(0, n);
        refill_5 = 1'b0;
        chk("rf_busy_cycles", n, 6);
        @(negedge clk);
        chk("rf_busy_stock5", stock_5_0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
